// File: rtl/packet_injector.sv
// packet_injector: builds HEAD/BODY/TAIL flits from (col,row,len) requests and len payload words; ports req_* in, data_* in, flit_* out, busy_o/err_o/pkt_cnt_o status
module packet_injector #(
  parameter int PACKET_ADDR_COL_W = 4,
  parameter int PACKET_ADDR_ROW_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [PACKET_ADDR_COL_W-1:0] req_col_i,
  input  logic [PACKET_ADDR_ROW_W-1:0] req_row_i,
  input  logic [LEN_W-1:0]             req_len_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
  input  logic [DATA_W-1:0]            data_i,
  output logic                         flit_valid_o,
  input  logic                         flit_ready_i,
  output logic [DATA_W+1:0]            flit_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [7:0]                   pkt_cnt_o
);
  localparam logic [1:0] IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2, TAIL_WAIT = 2'd3;
  logic [1:0] state;
  logic [LEN_W-1:0] remaining;
  logic req_hs, data_hs;
  assign req_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign data_ready_o = state == BODY && (!flit_valid_o || flit_ready_i);
  assign req_hs = req_valid_i && req_ready_o;
  assign data_hs = data_valid_i && data_ready_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      remaining <= '0;
      flit_valid_o <= 1'b0;
      flit_o <= '0;
      err_o <= 1'b0;
      pkt_cnt_o <= 8'd0;
    end else begin
      err_o <= req_hs && req_len_i == '0;
      case (state)
        IDLE:
          if (req_hs && req_len_i != '0) begin
            state <= HEAD;
            remaining <= req_len_i;
            flit_valid_o <= 1'b1;
            flit_o <= {2'b10, DATA_W'({req_row_i, req_col_i})};
          end
        HEAD:
          if (flit_ready_i) begin
            state <= BODY;
            flit_valid_o <= 1'b0;
          end
        BODY:
          if (data_hs) begin
            flit_valid_o <= 1'b1;
            flit_o <= {remaining == LEN_W'(1) ? 2'b01 : 2'b00, data_i};
            remaining <= remaining - LEN_W'(1);
            state <= remaining == LEN_W'(1) ? TAIL_WAIT : BODY;
          end else if (flit_ready_i) flit_valid_o <= 1'b0;
        TAIL_WAIT:
          if (flit_ready_i) begin
            state <= IDLE;
            flit_valid_o <= 1'b0;
            pkt_cnt_o <= pkt_cnt_o + 8'd1;
          end
      endcase
    end
endmodule

// File: tb/tb_packet_injector.sv
// tb_packet_injector: randomized self-checking bench with a flit-queue reference model for packet_injector
module tb_packet_injector;
  localparam int FW = 10;
  logic clk = 0, rst = 1;
  logic req_valid_i = 0, req_ready_o;
  logic [3:0] req_col_i = 0, req_row_i = 0, req_len_i = 0;
  logic data_valid_i = 0, data_ready_o;
  logic [7:0] data_i = 0;
  logic flit_valid_o, flit_ready_i = 1;
  logic [FW-1:0] flit_o;
  logic busy_o, err_o;
  logic [7:0] pkt_cnt_o;
  int checks = 0, failures = 0;
  logic [FW-1:0] exp_q[$];
  logic [7:0] exp_cnt = 0;
  logic [7:0] pw[16];
  int stall_pct = 0, gap_pct = 0;
  bit ready_manual = 0, abort = 0, noise = 0;

  packet_injector dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_col_i(req_col_i), .req_row_i(req_row_i), .req_len_i(req_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i), .flit_o(flit_o),
    .busy_o(busy_o), .err_o(err_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    if (!ready_manual) flit_ready_i = $urandom_range(99) >= stall_pct;
  end

  // Scoreboard: every accepted flit must be the next one the model predicted; a new flit may only
  // appear the cycle after an accepted nonzero request or payload word; a stalled flit must hold.
  initial begin
    logic pv, pr, p_req, p_data, p_zero, new_flit;
    logic [FW-1:0] pf, e;
    pv = 0; pr = 0; p_req = 0; p_data = 0; p_zero = 0; pf = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pr = 0; p_req = 0; p_data = 0; p_zero = 0;
      end else begin
        checks++;
        if (pv && !pr && (flit_valid_o !== 1'b1 || flit_o !== pf)) begin
          failures++;
          $display("FAIL hold_stable got v=%b f=%h exp v=1 f=%h", flit_valid_o, flit_o, pf);
        end
        new_flit = flit_valid_o && (!pv || pr);
        checks++;
        if (new_flit !== (p_data || (p_req && !p_zero))) begin
          failures++;
          $display("FAIL new_flit got=%b exp=%b", new_flit, p_data || (p_req && !p_zero));
        end
        checks++;
        if (err_o !== (p_req && p_zero)) begin
          failures++;
          $display("FAIL err_pulse got=%b exp=%b", err_o, p_req && p_zero);
        end
        if (!busy_o && data_ready_o) begin
          failures++;
          $display("FAIL data_ready_idle got=1 exp=0");
        end
        if (flit_valid_o && flit_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_flit got=%h exp=none", flit_o);
          end else begin
            e = exp_q.pop_front();
            if (flit_o !== e) begin
              failures++;
              $display("FAIL flit_seq got=%h exp=%h", flit_o, e);
            end
            if (e[9:8] == 2'b01) exp_cnt++;
          end
        end
        pv = flit_valid_o; pr = flit_ready_i; pf = flit_o;
        p_req = req_valid_i && req_ready_o; p_zero = req_len_i == 0;
        p_data = data_valid_i && data_ready_o;
      end
    end
  end

  task automatic drive_noise();
    req_valid_i = noise ? 1'($urandom) : 1'b0;
    req_len_i = 4'($urandom);
    req_col_i = 4'($urandom);
    req_row_i = 4'($urandom);
  endtask

  task automatic send_packet(input logic [3:0] col, input logic [3:0] row, input logic [3:0] len, input bit rnd);
    int n, idx;
    bit hs;
    logic [FW-1:0] head;
    if (rnd) for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
    head = {2'b10, row, col};
    exp_q.push_back(head);
    for (int i = 0; i < int'(len); i++) exp_q.push_back({i == int'(len) - 1 ? 2'b01 : 2'b00, pw[i]});
    req_valid_i = 1; req_col_i = col; req_row_i = row; req_len_i = len;
    n = 0;
    do begin
      @(negedge clk);
      hs = req_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 100 && !abort);
    req_valid_i = 0;
    if (abort) return;
    checks++;
    if (!hs || flit_valid_o !== 1'b1 || flit_o !== head) begin
      failures++;
      $display("FAIL head_latency got v=%b f=%h exp v=1 f=%h", flit_valid_o, flit_o, head);
    end
    idx = 0; n = 0;
    while (idx < int'(len) && n < 1000 && !abort) begin
      data_valid_i = $urandom_range(99) >= gap_pct;
      data_i = pw[idx];
      drive_noise();
      @(negedge clk);
      hs = data_valid_i && data_ready_o;
      if (!abort) begin
        checks++;
        if (req_ready_o !== 1'b0) begin
          failures++;
          $display("FAIL req_ready_busy got=%b exp=0", req_ready_o);
        end
      end
      @(posedge clk);
      #1;
      if (hs) idx++;
      n++;
    end
    data_valid_i = 0; req_valid_i = 0;
    if (abort) return;
    n = 0;
    while (exp_q.size() != 0 && n < 1000 && !abort) begin
      drive_noise();
      @(negedge clk);
      if (!abort) begin
        checks++;
        if (req_ready_o !== 1'b0) begin
          failures++;
          $display("FAIL req_ready_tail got=%b exp=0", req_ready_o);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_valid_i = 0;
    if (abort) return;
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0 || pkt_cnt_o !== exp_cnt) begin
      failures++;
      $display("FAIL pkt_done got left=%0d busy=%b cnt=%0d exp left=0 busy=0 cnt=%0d", exp_q.size(), busy_o, pkt_cnt_o, exp_cnt);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (flit_valid_o !== 0 || flit_o !== 0 || err_o !== 0 || busy_o !== 0 || pkt_cnt_o !== 0 || data_ready_o !== 0) begin
      failures++;
      $display("FAIL reset_state got v=%b f=%h e=%b b=%b c=%0d dr=%b exp all 0", flit_valid_o, flit_o, err_o, busy_o, pkt_cnt_o, data_ready_o);
    end
    @(posedge clk);
    #1;
    rst = 0;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready_o);
    end
  endtask

  task automatic test_single();
    pw[0] = 8'hA1; pw[1] = 8'hA2; pw[2] = 8'hA3;
    send_packet(4'd3, 4'd2, 4'd3, 0);
    checks++;
    if (pkt_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL single_cnt got=%0d exp=1", pkt_cnt_o);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] c;
    c = pkt_cnt_o;
    req_valid_i = 1; req_len_i = 0; req_col_i = 4'd7; req_row_i = 4'd9;
    @(posedge clk);
    #1;
    req_valid_i = 0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || flit_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL zero_len got e=%b b=%b v=%b exp e=1 b=0 v=0", err_o, busy_o, flit_valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_o !== 1'b0 || flit_valid_o !== 1'b0 || pkt_cnt_o !== c) begin
      failures++;
      $display("FAIL zero_len_after got e=%b v=%b c=%0d exp e=0 v=0 c=%0d", err_o, flit_valid_o, pkt_cnt_o, c);
    end
  endtask

  task automatic stall_on(input logic [1:0] id);
    int n;
    logic [FW-1:0] f;
    n = 0;
    while (!(flit_valid_o && flit_o[9:8] == id) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    f = flit_o;
    flit_ready_i = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (n >= 200 || flit_valid_o !== 1'b1 || flit_o !== f) begin
      failures++;
      $display("FAIL stall_hold got v=%b f=%h exp v=1 f=%h", flit_valid_o, flit_o, f);
    end
    flit_ready_i = 1;
  endtask

  task automatic test_stall();
    ready_manual = 1;
    flit_ready_i = 1;
    gap_pct = 0;
    fork
      send_packet(4'd5, 4'd6, 4'd2, 1);
      begin
        stall_on(2'b10);
        stall_on(2'b01);
      end
    join
    ready_manual = 0;
  endtask

  task automatic test_random(input int pkts, input int sp, input int gp, input bit nz);
    stall_pct = sp; gap_pct = gp; noise = nz;
    for (int i = 0; i < pkts; i++)
      send_packet(4'($urandom), 4'($urandom), i == 0 ? 4'd15 : 4'($urandom_range(15, 1)), 1);
    stall_pct = 0; gap_pct = 0; noise = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 4; i++) pw[i] = 8'h30 + 8'(i);
    fork
      send_packet(4'd3, 4'd2, 4'd4, 0);
    join_none
    n = 0;
    while (!(flit_valid_o && flit_o == {2'b00, pw[1]}) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    abort = 1;
    rst = 1;
    #1;
    checks++;
    if (n >= 100 || flit_valid_o !== 0 || flit_o !== 0 || busy_o !== 0 || pkt_cnt_o !== 0 || err_o !== 0) begin
      failures++;
      $display("FAIL reset_mid got v=%b f=%h b=%b c=%0d e=%b exp all 0", flit_valid_o, flit_o, busy_o, pkt_cnt_o, err_o);
    end
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
    abort = 0;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready got=%b exp=1", req_ready_o);
    end
    send_packet(4'd1, 4'd4, 4'd1, 1);
    checks++;
    if (pkt_cnt_o !== 8'd1) begin
      failures++;
      $display("FAIL reset_mid_cnt got=%0d exp=1", pkt_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 256; i++) send_packet(4'($urandom), 4'($urandom), 4'd1, 1);
    checks++;
    if (pkt_cnt_o !== 8'd0) begin
      failures++;
      $display("FAIL cnt_wrap got=%0d exp=0", pkt_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_stall();
    test_random(15, 0, 60, 0);
    test_random(30, 30, 30, 1);
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
